// File: rtl/layer_seq.sv
// layer_seq: walks a table of layer descriptors. For each layer it loads
// the geometry, requests a weight and an optional bias load, and runs
// nbatch batches. It then drains the output stage and moves to the next
// layer.
module layer_seq #(
  parameter int NL = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [63:0]   cfg_data,
  input  logic          start,
  input  logic [AW:0]   nlayer,
  input  logic          abort,
  input  logic          wdone,
  input  logic          bdone,
  input  logic          batch_done,
  input  logic          out_busy,
  output logic          run,
  output logic          wwrite,
  output logic          bwrite,
  output logic          last,
  output logic          backprop,
  output logic [11:0]   ss,
  output logic [11:0]   ds,
  output logic [3:0]    id,
  output logic [3:0]    od,
  output logic [9:0]    fs,
  output logic [9:0]    ks,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] layer
);

  typedef enum logic [2:0] {IDLE, LOAD, WLOAD, BLOAD, RUN, DRAIN, NEXT, DONE} state_t;

  state_t        state, state_n;
  logic [63:0]   tbl [NL];
  logic [AW-1:0] layer_n;
  logic [7:0]    cnt, cnt_n;
  logic [AW:0]   nl, nl_n;
  logic [AW:0]   nl_last;
  logic [7:0]    nbatch;
  logic          nobias;
  logic [7:0]    nb_last;

  // nbatch of 0 behaves like 1, so the final batch index is 0 in both cases
  assign nb_last = (nbatch == 8'd0) ? 8'd0 : nbatch - 8'd1;
  assign nl_last = nl - (AW+1)'(1);

  // Next-state, layer index, batch counter and layer-count selection
  always_comb begin
    state_n = state;
    layer_n = layer;
    cnt_n   = cnt;
    nl_n    = nl;
    case (state)
      IDLE: begin
        if (start) begin
          nl_n    = nlayer;
          layer_n = '0;
          state_n = (nlayer != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        cnt_n   = 8'd0;
        state_n = WLOAD;
      end
      WLOAD: if (wdone) state_n = nobias ? RUN : BLOAD;
      BLOAD: if (bdone) state_n = RUN;
      RUN: begin
        if (batch_done) begin
          if (cnt == nb_last) state_n = DRAIN;
          else                cnt_n   = cnt + 8'd1;
        end
      end
      DRAIN: if (!out_busy) state_n = NEXT;
      NEXT: begin
        if ({1'b0, layer} == nl_last) begin
          state_n = DONE;
        end else begin
          layer_n = layer + AW'(1);
          state_n = LOAD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort overrides any transition chosen above
    if (abort && state != IDLE) state_n = IDLE;
  end

  // State, control outputs (decoded from the next state so they are registered)
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      layer  <= '0;
      cnt    <= 8'd0;
      nl     <= '0;
      run    <= 1'b0;
      wwrite <= 1'b0;
      bwrite <= 1'b0;
      last   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      layer  <= layer_n;
      cnt    <= cnt_n;
      nl     <= nl_n;
      run    <= (state_n == RUN) || (state_n == DRAIN);
      wwrite <= (state_n == WLOAD);
      bwrite <= (state_n == BLOAD);
      last   <= ((state_n == RUN) && (cnt_n == nb_last)) || (state_n == DRAIN);
      busy   <= (state_n != IDLE) && (state_n != DONE);
      done   <= (state_n == DONE);
    end
  end

  // Geometry and per-layer fields latched when LOAD is left
  always_ff @(posedge clk) begin
    if (rst) begin
      ss       <= '0;
      ds       <= '0;
      id       <= '0;
      od       <= '0;
      fs       <= '0;
      ks       <= '0;
      backprop <= 1'b0;
      nbatch   <= 8'd0;
      nobias   <= 1'b0;
    end else if (state == LOAD) begin
      ss       <= tbl[layer][11:0];
      ds       <= tbl[layer][23:12];
      id       <= tbl[layer][27:24];
      od       <= tbl[layer][31:28];
      fs       <= tbl[layer][41:32];
      ks       <= tbl[layer][51:42];
      nbatch   <= tbl[layer][59:52];
      backprop <= tbl[layer][60];
      nobias   <= tbl[layer][61];
    end
  end

  // Descriptor table; configuration is accepted only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) tbl[i] <= '0;
    end else if (cfg_we && state == IDLE) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_layer_seq.sv
// Directed testbench for layer_seq.
module tb_layer_seq;

  localparam int NL = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [63:0]   cfg_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   nlayer = '0;
  logic          abort = 1'b0;
  logic          wdone = 1'b0;
  logic          bdone = 1'b0;
  logic          batch_done = 1'b0;
  logic          out_busy = 1'b0;
  logic          run, wwrite, bwrite, last, backprop, busy, done;
  logic [11:0]   ss, ds;
  logic [3:0]    id, od;
  logic [9:0]    fs, ks;
  logic [AW-1:0] layer;

  int checks = 0;
  int errors = 0;

  layer_seq #(.NL(NL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .nlayer(nlayer), .abort(abort), .wdone(wdone), .bdone(bdone),
    .batch_done(batch_done), .out_busy(out_busy), .run(run), .wwrite(wwrite),
    .bwrite(bwrite), .last(last), .backprop(backprop), .ss(ss), .ds(ds), .id(id),
    .od(od), .fs(fs), .ks(ks), .busy(busy), .done(done), .layer(layer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [11:0] s, input logic [3:0] o,
                                     input logic [7:0] nb, input logic bp, input logic nob);
    return {2'b00, nob, bp, nb, 10'd7, 10'd3, o, 4'd2, 12'd16, s};
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if ({run, wwrite, bwrite, last, busy, done} !== 6'b0) begin errors++; $display("FAIL reset_ctl: got %b want 000000", {run, wwrite, bwrite, last, busy, done}); end
    checks++; if ({ss, od, layer, backprop} !== '0) begin errors++; $display("FAIL reset_geom: got ss=%h od=%h layer=%0d bp=%b want 0", ss, od, layer, backprop); end
  endtask

  task automatic test_basic();
    wr(0, mk(12'h0AA, 4'd5, 8'd3, 1'b0, 1'b0));
    start = 1'b1; nlayer = 1; tick(); start = 1'b0;
    checks++; if ({busy, wwrite} !== 2'b10) begin errors++; $display("FAIL basic_load: busy,wwrite got %b want 10", {busy, wwrite}); end
    tick(); tick();
    checks++; if ({wwrite, bwrite, run, od} !== {3'b100, 4'd5}) begin errors++; $display("FAIL basic_wload: got %b od=%0d want 100 od=5", {wwrite, bwrite, run}, od); end
    wdone = 1'b1; tick(); wdone = 1'b0;
    checks++; if ({wwrite, bwrite, run} !== 3'b010) begin errors++; $display("FAIL basic_bload: got %b want 010", {wwrite, bwrite, run}); end
    tick();
    checks++; if (bwrite !== 1'b1) begin errors++; $display("FAIL basic_bhold: got %b want 1", bwrite); end
    bdone = 1'b1; tick(); bdone = 1'b0;
    checks++; if ({wwrite, bwrite, run, last} !== 4'b0010) begin errors++; $display("FAIL basic_run: got %b want 0010", {wwrite, bwrite, run, last}); end
    batch_done = 1'b1; tick();
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL basic_last1: got %b want 0", last); end
    tick();
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL basic_last2: got %b want 1", last); end
    out_busy = 1'b1; tick(); batch_done = 1'b0; tick();
    checks++; if ({run, last, busy} !== 3'b111) begin errors++; $display("FAIL basic_drain: got %b want 111", {run, last, busy}); end
    out_busy = 1'b0; tick();
    checks++; if ({run, last, busy, done} !== 4'b0010) begin errors++; $display("FAIL basic_next: got %b want 0010", {run, last, busy, done}); end
    tick();
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL basic_done: got %b want 10", {done, busy}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_two_layers();
    int ndone = 0;
    wr(0, mk(12'h123, 4'd1, 8'd1, 1'b0, 1'b0));
    wr(1, mk(12'hABC, 4'd9, 8'd2, 1'b1, 1'b1));
    start = 1'b1; nlayer = 2; tick(); start = 1'b0; tick();
    checks++; if ({ss, layer} !== {12'h123, 3'd0}) begin errors++; $display("FAIL two_geom0: got ss=%h layer=%0d want 123 0", ss, layer); end
    wdone = 1'b1; tick(); wdone = 1'b0; bdone = 1'b1; tick(); bdone = 1'b0;
    checks++; if ({run, last} !== 2'b11) begin errors++; $display("FAIL two_run0_last: got %b want 11", {run, last}); end
    batch_done = 1'b1; tick(); batch_done = 1'b0; tick();
    checks++; if ({run, busy} !== 2'b01) begin errors++; $display("FAIL two_next_run: got %b want 01", {run, busy}); end
    tick();
    checks++; if ({layer, ss} !== {3'd1, 12'h123}) begin errors++; $display("FAIL two_load1: got layer=%0d ss=%h want 1 123", layer, ss); end
    tick();
    checks++; if ({ss, od, backprop, wwrite} !== {12'hABC, 4'd9, 2'b11}) begin errors++; $display("FAIL two_geom1: got ss=%h od=%0d bp=%b ww=%b want abc 9 1 1", ss, od, backprop, wwrite); end
    wdone = 1'b1; tick(); wdone = 1'b0;
    checks++; if ({bwrite, run, last} !== 3'b010) begin errors++; $display("FAIL two_nobias: got %b want 010", {bwrite, run, last}); end
    batch_done = 1'b1; tick();
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL two_last1: got %b want 1", last); end
    tick(); batch_done = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (done === 1'b1) ndone++; end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL two_done_count: got %0d want 1", ndone); end
  endtask

  task automatic test_nbatch(input logic [7:0] nb);
    wr(0, mk(12'h055, 4'd4, nb, 1'b0, 1'b1));
    start = 1'b1; nlayer = 1; tick(); start = 1'b0; tick();
    wdone = 1'b1; tick(); wdone = 1'b0;
    checks++; if ({run, last} !== 2'b11) begin errors++; $display("FAIL nbatch%0d_first: got %b want 11", nb, {run, last}); end
    batch_done = 1'b1; tick(); batch_done = 1'b0;
    checks++; if ({run, last, busy} !== 3'b111) begin errors++; $display("FAIL nbatch%0d_drain: got %b want 111", nb, {run, last, busy}); end
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nbatch%0d_done: got %b want 1", nb, done); end
    tick();
  endtask

  task automatic test_abort();
    wr(0, mk(12'h077, 4'd6, 8'd3, 1'b0, 1'b1));
    start = 1'b1; nlayer = 1; tick(); start = 1'b0; tick();
    wdone = 1'b1; tick(); wdone = 1'b0;
    batch_done = 1'b1; tick(); batch_done = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if ({run, last, busy, done, wwrite, bwrite} !== 6'b0) begin errors++; $display("FAIL abort_idle: got %b want 000000", {run, last, busy, done, wwrite, bwrite}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone: got %b want 0", done); end
    start = 1'b1; nlayer = 1; tick(); start = 1'b0; tick();
    checks++; if ({wwrite, layer, busy} !== {1'b1, 3'd0, 1'b1}) begin errors++; $display("FAIL abort_restart: got ww=%b layer=%0d busy=%b want 1 0 1", wwrite, layer, busy); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_zero_and_cfg_busy();
    start = 1'b1; nlayer = 0; tick(); start = 1'b0;
    checks++; if ({done, busy, wwrite, run} !== 4'b1000) begin errors++; $display("FAIL zero_done: got %b want 1000", {done, busy, wwrite, run}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse: got %b want 0", done); end
    wr(0, mk(12'h111, 4'd1, 8'd1, 1'b0, 1'b1));
    wr(1, mk(12'h333, 4'd3, 8'd1, 1'b0, 1'b1));
    start = 1'b1; nlayer = 1; tick(); start = 1'b0; tick();
    wr(1, mk(12'h444, 4'd4, 8'd1, 1'b0, 1'b1));
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; nlayer = 2; tick(); start = 1'b0; tick();
    wdone = 1'b1; tick(); wdone = 1'b0;
    batch_done = 1'b1; tick(); batch_done = 1'b0;
    tick(); tick(); tick();
    checks++; if ({ss, od, layer} !== {12'h333, 4'd3, 3'd1}) begin errors++; $display("FAIL cfg_busy_dropped: got ss=%h od=%0d layer=%0d want 333 3 1", ss, od, layer); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_reset_bload();
    wr(0, mk(12'h0F0, 4'd7, 8'd2, 1'b1, 1'b0));
    start = 1'b1; nlayer = 1; tick(); start = 1'b0; tick();
    wdone = 1'b1; tick(); wdone = 1'b0;
    checks++; if (bwrite !== 1'b1) begin errors++; $display("FAIL rstb_bload: got %b want 1", bwrite); end
    rst = 1'b1; abort = 1'b1; tick(); rst = 1'b0; abort = 1'b0;
    checks++; if ({bwrite, wwrite, run, busy, done, od, ss, backprop} !== '0) begin errors++; $display("FAIL rstb_outs: got bw=%b busy=%b od=%0d ss=%h bp=%b want 0", bwrite, busy, od, ss, backprop); end
    start = 1'b1; nlayer = 1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstb_idle: busy got %b want 1", busy); end
    tick();
    wdone = 1'b1; tick(); wdone = 1'b0;
    checks++; if ({od, ss, bwrite} !== {4'd0, 12'd0, 1'b1}) begin errors++; $display("FAIL rstb_table: got od=%0d ss=%h bw=%b want 0 000 1", od, ss, bwrite); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_layers();
    test_nbatch(8'd0);
    test_nbatch(8'd1);
    test_abort();
    test_zero_and_cfg_busy();
    test_reset_bload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
